seg_scan_ctrl: RTL



---
 rtl/seg_scan_ctrl_if.sv | 20 ++
 rtl/seg_scan_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl_if.sv
// Display front-end bus: amount/load request in,
// conversion status and multiplexed segment drive out.
interface seg_scan_ctrl_if;
    logic [19:0] number;
    logic        upd;
    logic        busy;
    logic        ovf;
    logic [5:0]  sel;
    logic [7:0]  seg;

    modport master (
        output number, upd,
        input  busy, ovf, sel, seg
    );

    modport slave (
        input  number, upd,
        output busy, ovf, sel, seg
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Six-digit seven-segment front end: binary to BCD by
// shift-add-3, then time-multiplexed active-low scan.
module seg_scan_ctrl #(
    parameter int CLK_DIV = 50000,
    parameter int DP_POS  = 1,
    parameter bit BLANK   = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_scan_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
    // With no decimal point shown, blanking may reach down to the tens digit.
    localparam int DP_LIM = (DP_POS < 6) ? DP_POS : 0;
    localparam logic [7:0] SEG_RST = (DP_POS == 0) ? 8'h40 : 8'hC0;

    logic [1:0]    r_state;
    logic [43:0]   r_sh;
    logic [4:0]    r_cnt;
    logic          r_big;
    logic          r_busy;
    logic          r_ovf;
    logic [23:0]   r_buf;
    logic [PW-1:0] r_pre;
    logic [2:0]    r_idx;
    logic [5:0]    r_sel;
    logic [7:0]    r_seg;

    logic [43:0]   w_adj;
    logic          w_term;
    logic [2:0]    w_idx_nxt;
    logic [3:0]    w_dig;
    logic [5:0]    w_zero;
    logic          w_blank;
    logic          w_dp;
    logic [7:0]    w_pat;
    logic [7:0]    w_seg_nxt;

    // Add-3 correction on every BCD nibble that would overflow on the next shift.
    always_comb begin
        w_adj = r_sh;
        for (int k = 0; k < 6; k++) begin
            if (r_sh[20+4*k +: 4] >= 4'd5)
                w_adj[20+4*k +: 4] = r_sh[20+4*k +: 4] + 4'd3;
        end
    end

    // Converter FSM; oversize values saturate to 999999 with ovf.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_big   <= 1'b0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
            r_buf   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.upd) begin
                        r_sh    <= {24'b0, bus.number};
                        r_cnt   <= '0;
                        r_big   <= (bus.number > 20'd999999);
                        r_busy  <= 1'b1;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_sh  <= {w_adj[42:0], 1'b0};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd19)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    r_buf   <= r_big ? 24'h999999 : r_sh[43:20];
                    r_ovf   <= r_big;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Next scan position and the segment pattern for that digit.
    always_comb begin
        w_term    = (r_pre == PRE_MAX);
        w_idx_nxt = r_idx;
        if (w_term)
            w_idx_nxt = (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
        w_dig = r_buf[{w_idx_nxt, 2'b00} +: 4];
        w_zero[5] = (r_buf[23:20] == 4'd0);
        for (int j = 4; j >= 0; j--)
            w_zero[j] = w_zero[j+1] && (r_buf[4*j +: 4] == 4'd0);
        w_blank = BLANK && (int'(w_idx_nxt) > DP_LIM) &&
                  (w_idx_nxt != 3'd0) && w_zero[w_idx_nxt];
        w_dp = (int'(w_idx_nxt) == DP_POS);
        case (w_dig)
            4'd0:    w_pat = 8'hC0;
            4'd1:    w_pat = 8'hF9;
            4'd2:    w_pat = 8'hA4;
            4'd3:    w_pat = 8'hB0;
            4'd4:    w_pat = 8'h99;
            4'd5:    w_pat = 8'h92;
            4'd6:    w_pat = 8'h82;
            4'd7:    w_pat = 8'hF8;
            4'd8:    w_pat = 8'h80;
            4'd9:    w_pat = 8'h90;
            default: w_pat = 8'hFF;
        endcase
        w_seg_nxt = w_blank ? 8'hFF : {~w_dp, w_pat[6:0]};
    end

    // Prescaler, digit index and the registered sel/seg pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
            r_idx <= '0;
            r_sel <= 6'b011111;
            r_seg <= SEG_RST;
        end else begin
            r_pre <= w_term ? '0 : r_pre + 1'b1;
            r_idx <= w_idx_nxt;
            r_sel <= ~(6'b100000 >> w_idx_nxt);
            r_seg <= w_seg_nxt;
        end
    end

    assign bus.busy = r_busy;
    assign bus.ovf  = r_ovf;
    assign bus.sel  = r_sel;
    assign bus.seg  = r_seg;
endmodule
